block_drop_ctrl: RTL and testbench

Falling-block game controller; sits directly downstream of the clock divider and consumes its `block_clk` output as the gravity rate. Detects `block_clk` rising edges in the `sys_clk` domain, moves a single-cell block down a ROWS×COLS occupancy board, and applies debounced left/right pulses. Locks landed cells, clears full rows and counts them. Feeds the display/VGA renderer with board, active-block position and score.

---
 rtl/block_game_pkg.sv | 30 +++
 rtl/rise_detect.sv | 28 ++
 rtl/block_drop_ctrl.sv | 172 +++++++++++++++++
 tb/tb_block_drop_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | block_game_pkg                                                       |
// | Shared types and helpers for the falling-block game datapath.        |
// |   drop_state_t : controller state encoding                           |
// |   BOARD_ROWS / BOARD_COLS : default board geometry                   |
// |   cell_idx()   : flat board bit index of (row, col)                  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package block_game_pkg;

  localparam int BOARD_ROWS = 16;
  localparam int BOARD_COLS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_FALL  = 3'd2,
    ST_LOCK  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_OVER  = 3'd5
  } drop_state_t;

  // Row-major flattening: bit r*cols+c holds row r, column c.
  function automatic int cell_idx(input int row, input int col, input int cols = BOARD_COLS);
    return row * cols + col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rise_detect                                                          |
// | Registered 1-bit rising-edge detector for a sys_clk-synchronous      |
// | input. The pulse is combinational: high while din=1 and the previous |
// | sample was 0.                                                        |
// |   sys_clk : clock          sys_rst : synchronous active-high reset   |
// |   din     : sampled input  pulse   : rising-edge pulse               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rise_detect (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic din,
  output logic pulse
);

  logic r_din_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_din_q <= 1'b0;
    else         r_din_q <= din;
  end

  assign pulse = din & ~r_din_q;

endmodule
`default_nettype wire

// File: rtl/block_drop_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | block_drop_ctrl                                                      |
// | Falling single-cell block controller. Gravity ticks come from rising |
// | edges of block_clk (sys_clk-synchronous data, not a clock). Moves    |
// | the active block, locks it, clears full rows and counts them.        |
// |   sys_clk, sys_rst        : clock, synchronous active-high reset     |
// |   block_clk               : divided gravity rate                     |
// |   start                   : begin game from IDLE or OVER             |
// |   move_left, move_right   : lateral move pulses                      |
// |   board                   : locked cells, bit r*COLS+c               |
// |   block_row, block_col    : active block position                    |
// |   block_valid, game_over  : FALL / OVER indicators                   |
// |   drop_tick               : registered gravity tick                  |
// |   score                   : saturating cleared-row count             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module block_drop_ctrl
  import block_game_pkg::*;
#(
  parameter int ROWS    = BOARD_ROWS,
  parameter int COLS    = BOARD_COLS,
  parameter int SCORE_W = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     block_clk,
  input  logic                     start,
  input  logic                     move_left,
  input  logic                     move_right,
  output logic [ROWS*COLS-1:0]     board,
  output logic [$clog2(ROWS)-1:0]  block_row,
  output logic [$clog2(COLS)-1:0]  block_col,
  output logic                     block_valid,
  output logic                     drop_tick,
  output logic [SCORE_W-1:0]       score,
  output logic                     game_over
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  localparam logic [RW-1:0]      C_ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0]      C_COL_LAST  = CW'(COLS - 1);
  localparam logic [CW-1:0]      C_COL_SPAWN = CW'(COLS / 2);
  localparam logic [SCORE_W-1:0] C_SCORE_MAX = '1;

  drop_state_t          r_state, w_state_nx;
  logic [COLS-1:0]      r_rows    [ROWS];
  logic [COLS-1:0]      w_rows_nx [ROWS];
  logic [RW-1:0]        r_row, w_row_nx;
  logic [CW-1:0]        r_col, w_col_nx;
  logic [SCORE_W-1:0]   r_score, w_score_nx;
  logic                 r_drop_tick;
  logic                 w_tick;

  rise_detect u_gravity_edge (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .din     (block_clk),
    .pulse   (w_tick)
  );

  // Neighbour indices may wrap at the board edges; every use is gated by
  // the matching bounds test, so the wrapped cell is never consulted.
  logic [RW-1:0] w_row_below;
  logic [CW-1:0] w_col_left;
  logic [CW-1:0] w_col_right;
  logic          w_blocked_below;
  logic          w_can_left;
  logic          w_can_right;
  logic          w_row_full;

  assign w_row_below     = r_row + 1'b1;
  assign w_col_left      = r_col - 1'b1;
  assign w_col_right     = r_col + 1'b1;
  assign w_blocked_below = (r_row == C_ROW_LAST) || r_rows[w_row_below][r_col];
  assign w_can_left      = (r_col != '0) && !r_rows[r_row][w_col_left];
  assign w_can_right     = (r_col != C_COL_LAST) && !r_rows[r_row][w_col_right];
  // A single-cell block can only complete the row it landed in.
  assign w_row_full      = &r_rows[r_row];

  always_comb begin
    w_state_nx = r_state;
    w_row_nx   = r_row;
    w_col_nx   = r_col;
    w_score_nx = r_score;
    w_rows_nx  = r_rows;

    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nx = ST_SPAWN;
      end

      ST_SPAWN: begin
        w_row_nx   = '0;
        w_col_nx   = C_COL_SPAWN;
        w_state_nx = r_rows[0][C_COL_SPAWN] ? ST_OVER : ST_FALL;
      end

      ST_FALL: begin
        // Gravity wins over lateral input; a move in the tick cycle is dropped.
        if (w_tick) begin
          if (w_blocked_below) w_state_nx = ST_LOCK;
          else                 w_row_nx   = w_row_below;
        end else if (move_left && !move_right) begin
          if (w_can_left) w_col_nx = w_col_left;
        end else if (move_right && !move_left) begin
          if (w_can_right) w_col_nx = w_col_right;
        end
      end

      ST_LOCK: begin
        w_rows_nx[r_row][r_col] = 1'b1;
        w_state_nx              = ST_CLEAR;
      end

      ST_CLEAR: begin
        if (w_row_full) begin
          // Everything above the landed row drops by one; rows below stay.
          w_rows_nx[0] = '0;
          for (int i = 1; i < ROWS; i++) begin
            if (i <= int'(r_row)) w_rows_nx[i] = r_rows[i-1];
          end
          if (r_score != C_SCORE_MAX) w_score_nx = r_score + 1'b1;
        end
        w_state_nx = ST_SPAWN;
      end

      ST_OVER: begin
        if (start) begin
          for (int i = 0; i < ROWS; i++) w_rows_nx[i] = '0;
          w_score_nx = '0;
          w_state_nx = ST_SPAWN;
        end
      end

      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_score     <= '0;
      r_drop_tick <= 1'b0;
      for (int i = 0; i < ROWS; i++) r_rows[i] <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_row       <= w_row_nx;
      r_col       <= w_col_nx;
      r_score     <= w_score_nx;
      r_drop_tick <= w_tick;
      r_rows      <= w_rows_nx;
    end
  end

  for (genvar g = 0; g < ROWS; g++) begin : g_board_row
    assign board[cell_idx(g, 0, COLS) +: COLS] = r_rows[g];
  end

  assign block_row   = r_row;
  assign block_col   = r_col;
  assign block_valid = (r_state == ST_FALL);
  assign game_over   = (r_state == ST_OVER);
  assign drop_tick   = r_drop_tick;
  assign score       = r_score;

endmodule
`default_nettype wire

// File: tb/tb_block_drop_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_block_drop_ctrl                                                   |
// | Self-checking bench: directed game scenarios plus random play,       |
// | compared against a move-level model of the game rules.               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_block_drop_ctrl;

  localparam int ROWS    = 16;
  localparam int COLS    = 8;
  localparam int SCORE_W = 8;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst = 1'b1;
  logic                 block_clk = 1'b0;
  logic                 start = 1'b0;
  logic                 move_left = 1'b0;
  logic                 move_right = 1'b0;
  logic [ROWS*COLS-1:0] board;
  logic [3:0]           block_row;
  logic [2:0]           block_col;
  logic                 block_valid;
  logic                 drop_tick;
  logic [SCORE_W-1:0]   score;
  logic                 game_over;

  block_drop_ctrl #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SCORE_W)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .block_clk   (block_clk),
    .start       (start),
    .move_left   (move_left),
    .move_right  (move_right),
    .board       (board),
    .block_row   (block_row),
    .block_col   (block_col),
    .block_valid (block_valid),
    .drop_tick   (drop_tick),
    .score       (score),
    .game_over   (game_over)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  // Game model: board as a grid, block position, score, phase flags.
  bit m_b [ROWS][COLS];
  int m_row, m_col, m_score;
  bit m_valid, m_over;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] m_board();
    logic [127:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[r*COLS + c] = m_b[r][c];
    return v;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, "_board"}, board, m_board());
    chk({tag, "_row"},   block_row, m_row);
    chk({tag, "_col"},   block_col, m_col);
    chk({tag, "_valid"}, block_valid, m_valid);
    chk({tag, "_over"},  game_over, m_over);
    chk({tag, "_score"}, score, m_score);
  endtask

  function automatic void m_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m_b[r][c] = 1'b0;
    m_score = 0;
  endfunction

  function automatic void m_reset();
    m_clear();
    m_row = 0; m_col = 0; m_valid = 0; m_over = 0;
  endfunction

  function automatic void m_spawn();
    m_row = 0;
    m_col = COLS / 2;
    m_over  = m_b[0][COLS/2];
    m_valid = !m_over;
  endfunction

  // One gravity step; returns 1 when the block lands (then the model
  // moves straight on to the next spawned block).
  function automatic bit m_tick();
    bit full;
    if (!m_valid) return 1'b0;
    if (m_row == ROWS-1 || m_b[m_row+1][m_col]) begin
      m_b[m_row][m_col] = 1'b1;
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (!m_b[m_row][c]) full = 1'b0;
      if (full) begin
        for (int r = m_row; r > 0; r--) m_b[r] = m_b[r-1];
        for (int c = 0; c < COLS; c++) m_b[0][c] = 1'b0;
        if (m_score < (1 << SCORE_W) - 1) m_score++;
      end
      m_valid = 1'b0;
      m_spawn();
      return 1'b1;
    end
    m_row++;
    return 1'b0;
  endfunction

  task automatic do_reset();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    m_reset();
    chk_all("reset");
    chk("reset_drop_tick", drop_tick, 1'b0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    if (m_valid) begin
      chk_all("start_ignored");
    end else begin
      m_clear();
      step();
      m_spawn();
      chk_all("start");
    end
  endtask

  task automatic do_move(input bit l, input bit r);
    move_left = l; move_right = r;
    step();
    move_left = 1'b0; move_right = 1'b0;
    if (m_valid) begin
      if (l && !r && m_col > 0 && !m_b[m_row][m_col-1]) m_col--;
      else if (r && !l && m_col < COLS-1 && !m_b[m_row][m_col+1]) m_col++;
    end
    chk_all((l && r) ? "move_both" : (l ? "move_left" : "move_right"));
  endtask

  task automatic do_tick(input bit l, input bit r, input bit settle, output bit landed);
    block_clk = 1'b1; move_left = l; move_right = r;
    step();
    block_clk = 1'b0; move_left = 1'b0; move_right = 1'b0;
    landed = m_tick();
    if (!landed) chk_all("tick");
    step();
    if (landed && settle) begin
      step();
      step();
      chk_all("land");
    end
  endtask

  task automatic drop_at(input int c);
    bit landed;
    landed = 1'b0;
    for (int i = 0; i < COLS && m_col != c; i++) do_move(m_col > c, m_col < c);
    for (int i = 0; i < ROWS + 2 && !landed; i++) do_tick(1'b0, 1'b0, 1'b1, landed);
    chk("drop_landed", landed, 1'b1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit landed;
    int cnt;
    int sel;

    // Reset and first block
    do_reset();
    do_start();

    // Straight drop to the floor, then landing-to-respawn timing
    for (int i = 0; i < ROWS-1; i++) do_tick(1'b0, 1'b0, 1'b1, landed);
    block_clk = 1'b1;
    step();
    block_clk = 1'b0;
    landed = m_tick();
    chk("land_flag", landed, 1'b1);
    chk("lock_valid", block_valid, 1'b0);
    step();
    chk("clear_valid", block_valid, 1'b0);
    chk("lock_bit124", board[124], 1'b1);
    step();
    chk("spawn_valid", block_valid, 1'b0);
    step();
    chk_all("respawn");

    // Second block onto the first: occupies row 14, col 4
    drop_at(4);

    // Left-edge saturation and simultaneous lateral pulses
    for (int i = 0; i < 5; i++) do_move(1'b1, 1'b0);
    chk("left_edge_col", block_col, 0);
    do_move(1'b1, 1'b1);

    // Fill bottom row cols 0-6, then col 7 completes and clears it
    drop_at(0);
    drop_at(1);
    drop_at(2);
    drop_at(3);
    drop_at(5);
    drop_at(6);
    drop_at(7);
    chk("clear_score", score, 1);
    chk("clear_bottom_row", board[127:120], 8'h10);
    chk("clear_row14", board[119:112], 8'h00);

    // block_clk held high: one advance; tick beats a lateral pulse
    cnt = 0;
    block_clk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (drop_tick) cnt++;
    end
    block_clk = 1'b0;
    landed = m_tick();
    step();
    if (drop_tick) cnt++;
    chk("held_tick_count", cnt, 1);
    chk_all("held_high");
    do_tick(1'b0, 1'b1, 1'b1, landed);
    do_start();

    // Stack column 4 up to the top -> game over, then restart
    for (int k = 0; k < ROWS + 2 && !m_over; k++) drop_at(4);
    chk("game_over_flag", game_over, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_board", board, '0);
    chk("restart_score", score, 0);
    chk("restart_valid_early", block_valid, 1'b0);
    step();
    chk("restart_valid", block_valid, 1'b1);
    m_clear();
    m_spawn();
    chk_all("restart");

    // Random play against the model
    for (int n = 0; n < 600; n++) begin
      if (m_over) begin
        do_start();
      end else begin
        sel = $urandom_range(0, 11);
        if (sel <= 4)       do_tick(1'b0, 1'b0, 1'b1, landed);
        else if (sel == 5)  do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, landed);
        else if (sel <= 7)  do_move(1'b1, 1'b0);
        else if (sel <= 9)  do_move(1'b0, 1'b1);
        else if (sel == 10) do_move(1'b1, 1'b1);
        else                do_start();
      end
    end

    // Reset landing in the CLEAR cycle of a row-completing drop
    do_reset();
    do_start();
    for (int c = 0; c < COLS-1; c++) drop_at(c);
    for (int i = 0; i < COLS && m_col != COLS-1; i++) do_move(1'b0, 1'b1);
    landed = 1'b0;
    for (int i = 0; i < ROWS + 2 && !landed; i++) do_tick(1'b0, 1'b0, 1'b0, landed);
    chk("rst_clear_landed", landed, 1'b1);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    m_reset();
    chk_all("rst_in_clear");
    chk("rst_in_clear_drop_tick", drop_tick, 1'b0);
    do_start();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
